alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Execute stage sitting directly downstream of the register file: it consumes the two read operands (RD1/RD2), performs the requested ALU operation and drives the register file write port (WA/WD/WE1) with the result. Single-cycle ops complete with one cycle of latency; MUL runs as a 32-iteration shift-add sequence with back-pressure on the issue side via a valid/ready handshake. Registered condition flags accompany every write-back.

## Interface
- DATA_W, 32, operand/result width
- ADDR_W, 6, register address width (matches register file WA/RA)
- CLK  input  1  clock, all state on rising edge
- RST_N  input  1  reset, asynchronous, active-low
- IN_VALID  input  1  issue request valid
- IN_READY  output  1  stage can accept an issue this cycle
- OP  input  4  opcode
- A  input  DATA_W  operand 1 (from RD1)
- B  input  DATA_W  operand 2 (from RD2)
- DST  input  ADDR_W  destination register
- WA  output  ADDR_W  write-back address to register file
- WD  output  DATA_W  write-back data
- WE1  output  1  write-back enable, one-cycle pulse per completed op
- FLAGS  output  4  {Z,N,C,V}, registered with the write-back
- BUSY  output  1  multiply in progress

One clock; reset is asynchronous and active-low (ports CLK and RST_N).

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA (shift amount B[4:0]), 8 SLT (signed, result 1 or 0), 9 MUL (low DATA_W bits of unsigned product), 10-15 NOP.
- Accept: rising edge with IN_VALID && IN_READY. A, B, OP, DST are captured at that edge; inputs are don't-care afterwards.
- States: IDLE, MUL. IN_READY = (state == IDLE). BUSY = (state == MUL).
- IDLE, accept of single-cycle op: WD/WA/FLAGS load result, WE1 = 1 next cycle; remain IDLE.
- IDLE, accept of MUL: load multiplicand = A, multiplier = B, accumulator = 0, counter = 0; go to MUL. WE1 = 0 next cycle.
- MUL: each edge, if multiplier[0] add multiplicand to accumulator; multiplicand <<= 1; multiplier >>= 1; counter++. On the edge where counter reaches 31 (32nd iteration): load WD = final accumulator, WA = captured DST, WE1 = 1, return to IDLE.
- NOP opcodes: accepted, WE1 stays 0, WA/WD/FLAGS unchanged.
- WE1 deasserts the cycle after any write unless a new completing op loads it again (back-to-back single-cycle ops give WE1 high continuously).
- Flags: Z = (result == 0), N = result[DATA_W-1]. ADD: C = carry out, V = signed overflow. SUB: computed as A + ~B + 1, C = carry out (1 = no borrow), V = signed overflow. All other ops: C = V = 0.
- DST 0 is an ordinary register; no write suppression.
- Reset (any time, including mid-MUL): state IDLE, IN_READY = 1, BUSY = 0, WE1 = 0, WA = 0, WD = 0, FLAGS = 0, counter = 0; an in-flight MUL is discarded with no write.

## Timing
- Single-cycle op accepted at edge k: WE1/WA/WD/FLAGS valid in cycle after edge k (latency 1); throughput one op per cycle.
- MUL accepted at edge k: IN_READY and BUSY low after edge k through edge k+32; WE1 high after edge k+32 (latency 32); IN_READY high again in that same cycle, so a new op may be accepted at edge k+33.
- IN_VALID while IN_READY = 0 is ignored; the issuer must hold it.
- Outputs are purely registered; no combinational path from inputs to WA/WD/WE1/FLAGS. IN_READY depends only on state.

## Test plan
- Reset: RST_N low asynchronously mid-cycle -> all outputs 0, IN_READY = 1 immediately, before next edge.
- ADD A=0x7FFFFFFF, B=1, DST=5 -> next cycle WE1=1, WA=5, WD=0x80000000, FLAGS Z=0 N=1 C=0 V=1; SUB A=3, B=3 -> WD=0, Z=1, C=1, V=0.
- Back-to-back: AND, OR, XOR, SRA (A=0x80000000, B=4 -> 0xF8000000), SLT (A=-1, B=1 -> 1) on consecutive cycles -> WE1 high 5 consecutive cycles, correct WA/WD each cycle.
- MUL A=0x12345, B=0x100, DST=7 -> IN_READY low 32 cycles, IN_VALID ignored meanwhile, WE1 once at latency 32 with WD=0x1234500, WA=7; MUL 0xFFFFFFFF x 0xFFFFFFFF -> WD=0x00000001.
- Reset asserted at MUL iteration 10 -> no WE1 pulse; after release IN_READY=1 and a following ADD completes normally.
- NOP opcode 12 -> accepted, WE1 stays 0, WA/WD/FLAGS retain previous values.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute stage between register file read and write-back: single-cycle ALU ops
// plus a 32-iteration shift-add multiplier, with registered condition flags.
module alu_exec_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [3:0]        OP,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [ADDR_W-1:0] DST,
  output logic [ADDR_W-1:0] WA,
  output logic [DATA_W-1:0] WD,
  output logic              WE1,
  output logic [3:0]        FLAGS,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wa_q, wa_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic                we1_q, we1_d;
  logic [3:0]          flags_q, flags_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;

  logic [DATA_W:0]     sum_ext;
  logic [DATA_W:0]     diff_ext;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                alu_v;
  logic [4:0]          shamt;
  logic [DATA_W-1:0]   acc_next;
  logic                accept;

  assign IN_READY = (state_q == S_IDLE);
  assign BUSY     = (state_q == S_MUL);
  assign accept   = IN_VALID && IN_READY;
  assign WA       = wa_q;
  assign WD       = wd_q;
  assign WE1      = we1_q;
  assign FLAGS    = flags_q;

  always_comb begin
    shamt    = B[4:0];
    sum_ext  = {1'b0, A} + {1'b0, B};
    diff_ext = {1'b0, A} + {1'b0, ~B} + {{DATA_W{1'b0}}, 1'b1};
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (OP)
      OP_ADD: begin
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
        alu_v   = (A[DATA_W-1] == B[DATA_W-1]) && (alu_res[DATA_W-1] != A[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[DATA_W-1:0];
        alu_c   = diff_ext[DATA_W];
        alu_v   = (A[DATA_W-1] != B[DATA_W-1]) && (alu_res[DATA_W-1] != A[DATA_W-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLL:  alu_res = A << shamt;
      OP_SRL:  alu_res = A >> shamt;
      OP_SRA:  alu_res = $signed(A) >>> shamt;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_res = '0;
    endcase
  end

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Write-back registers only move on a completing op; everything else holds.
  always_comb begin
    state_d  = state_q;
    wa_d     = wa_q;
    wd_d     = wd_q;
    we1_d    = 1'b0;
    flags_d  = flags_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dst_d    = dst_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (OP == OP_MUL) begin
            mcand_d  = A;
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
            dst_d    = DST;
            state_d  = S_MUL;
          end else if (OP < OP_MUL) begin
            wa_d    = DST;
            wd_d    = alu_res;
            we1_d   = 1'b1;
            flags_d = {(alu_res == '0), alu_res[DATA_W-1], alu_c, alu_v};
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          wa_d    = dst_q;
          wd_d    = acc_next;
          we1_d   = 1'b1;
          flags_d = {(acc_next == '0), acc_next[DATA_W-1], 2'b00};
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      wa_q     <= '0;
      wd_q     <= '0;
      we1_q    <= 1'b0;
      flags_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dst_q    <= '0;
    end else begin
      state_q  <= state_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      we1_q    <= we1_d;
      flags_q  <= flags_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dst_q    <= dst_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: stimulus pushes expected write-backs,
// a monitor pops and compares on every WE1 pulse.
module tb_alu_exec_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;

  logic              CLK;
  logic              RST_N;
  logic              IN_VALID;
  logic              IN_READY;
  logic [3:0]        OP;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [ADDR_W-1:0] DST;
  logic [ADDR_W-1:0] WA;
  logic [DATA_W-1:0] WD;
  logic              WE1;
  logic [3:0]        FLAGS;
  logic              BUSY;

  typedef struct packed {
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [3:0]        flags;
  } exp_t;

  exp_t expQ[$];
  int   passCount = 0;
  int   totalCount = 0;
  bit   done = 0;

  alu_exec_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP(OP), .A(A), .B(B), .DST(DST), .WA(WA), .WD(WD), .WE1(WE1),
    .FLAGS(FLAGS), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    totalCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  // Drives one op for exactly one edge; callers only issue while the stage is idle.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [5:0] dst);
    OP = op; A = a; B = b; DST = dst; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic pushExp(input logic [5:0] wa, input logic [31:0] wd, input logic [3:0] flags);
    exp_t e;
    e.wa = wa; e.wd = wd; e.flags = flags;
    expQ.push_back(e);
  endtask

  // Waits for the multiply write-back after an accept; returns cycles to WE1.
  task automatic waitMul(output int cycles, output bit readyLow);
    cycles = 0;
    readyLow = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK); #1;
      cycles = i;
      if (WE1) break;
      if (IN_READY || !BUSY) readyLow = 1'b0;
    end
  endtask

  task automatic monitorLoop();
    exp_t e;
    while (!done) begin
      @(posedge CLK); #1;
      if (RST_N && WE1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_we1", {58'd0, WA}, 64'hFFFF);
        end else begin
          e = expQ.pop_front();
          checkOutput("wb_wa", {58'd0, WA}, {58'd0, e.wa});
          checkOutput("wb_wd", {32'd0, WD}, {32'd0, e.wd});
          checkOutput("wb_flags", {60'd0, FLAGS}, {60'd0, e.flags});
        end
      end
    end
  endtask

  task automatic stimulusMain();
    int cyc;
    bit rdyLow;
    RST_N = 1'b0; IN_VALID = 1'b0; OP = '0; A = '0; B = '0; DST = '0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
    checkOutput("reset_ready", {63'd0, IN_READY}, 64'd1);

    pushExp(6'd5, 32'h8000_0000, 4'b0101);
    applyStimulus(4'd0, 32'h7FFF_FFFF, 32'd1, 6'd5);
    pushExp(6'd6, 32'h0, 4'b1010);
    applyStimulus(4'd1, 32'd3, 32'd3, 6'd6);
    @(posedge CLK); #3;

    RST_N = 1'b0;
    #1;
    checkOutput("async_rst_ready", {63'd0, IN_READY}, 64'd1);
    checkOutput("async_rst_busy", {63'd0, BUSY}, 64'd0);
    checkOutput("async_rst_we1", {63'd0, WE1}, 64'd0);
    checkOutput("async_rst_wa", {58'd0, WA}, 64'd0);
    checkOutput("async_rst_wd", {32'd0, WD}, 64'd0);
    checkOutput("async_rst_flags", {60'd0, FLAGS}, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    pushExp(6'd1, 32'h00F0_1200, 4'b0000);
    pushExp(6'd2, 32'hF000_000F, 4'b0100);
    pushExp(6'd0, 32'h0000_0000, 4'b1000);
    pushExp(6'd3, 32'hF800_0000, 4'b0100);
    pushExp(6'd4, 32'h0000_0001, 4'b0000);
    applyStimulus(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 6'd1);
    checkOutput("b2b_we1_and", {63'd0, WE1}, 64'd1);
    applyStimulus(4'd3, 32'hF000_0000, 32'h0000_000F, 6'd2);
    checkOutput("b2b_we1_or", {63'd0, WE1}, 64'd1);
    applyStimulus(4'd4, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 6'd0);
    checkOutput("b2b_we1_xor", {63'd0, WE1}, 64'd1);
    applyStimulus(4'd7, 32'h8000_0000, 32'd4, 6'd3);
    checkOutput("b2b_we1_sra", {63'd0, WE1}, 64'd1);
    applyStimulus(4'd8, 32'hFFFF_FFFF, 32'd1, 6'd4);
    checkOutput("b2b_we1_slt", {63'd0, WE1}, 64'd1);

    pushExp(6'd10, 32'h0000_0020, 4'b0000);
    applyStimulus(4'd5, 32'd1, 32'h25, 6'd10);
    pushExp(6'd11, 32'h0000_0001, 4'b0000);
    applyStimulus(4'd6, 32'h8000_0000, 32'd31, 6'd11);
    @(posedge CLK); #1;

    // MUL with a held ADD that must wait until the multiply retires.
    pushExp(6'd7, 32'h0123_4500, 4'b0000);
    pushExp(6'd9, 32'h0000_0003, 4'b0000);
    applyStimulus(4'd9, 32'h0001_2345, 32'h0000_0100, 6'd7);
    OP = 4'd0; A = 32'd1; B = 32'd2; DST = 6'd9; IN_VALID = 1'b1;
    waitMul(cyc, rdyLow);
    checkOutput("mul_latency", 64'(cyc), 64'd32);
    checkOutput("mul_ready_low", {63'd0, rdyLow}, 64'd1);
    checkOutput("mul_done_ready", {63'd0, IN_READY}, 64'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    checkOutput("held_add_we1", {63'd0, WE1}, 64'd1);
    @(posedge CLK); #1;

    pushExp(6'd8, 32'h0000_0001, 4'b0000);
    applyStimulus(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd8);
    waitMul(cyc, rdyLow);
    checkOutput("mul2_latency", 64'(cyc), 64'd32);
    @(posedge CLK); #1;

    applyStimulus(4'd9, 32'd5, 32'd6, 6'd11);
    repeat (10) @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    checkOutput("mid_mul_rst_busy", {63'd0, BUSY}, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    rdyLow = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (WE1) rdyLow = 1'b1;
    end
    checkOutput("mid_mul_no_write", {63'd0, rdyLow}, 64'd0);
    checkOutput("post_rst_ready", {63'd0, IN_READY}, 64'd1);
    pushExp(6'd12, 32'd30, 4'b0000);
    applyStimulus(4'd0, 32'd10, 32'd20, 6'd12);

    pushExp(6'd13, 32'h0, 4'b1011);
    applyStimulus(4'd0, 32'h8000_0000, 32'h8000_0000, 6'd13);
    applyStimulus(4'd12, 32'd1, 32'd2, 6'd20);
    checkOutput("nop_we1", {63'd0, WE1}, 64'd0);
    checkOutput("nop_wa", {58'd0, WA}, 64'd13);
    checkOutput("nop_wd", {32'd0, WD}, 64'd0);
    checkOutput("nop_flags", {60'd0, FLAGS}, 64'hB);
    checkOutput("nop_ready", {63'd0, IN_READY}, 64'd1);
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
    done = 1'b1;
  endtask

  initial begin
    fork
      monitorLoop();
      stimulusMain();
    join
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
